// File: rtl/inv_zigzag_buffer.sv
// Inverse-zigzag ping-pong buffer: scatters zigzag-tagged coefficients into raster order, drains blocks to the IDCT.
// Optional build macro INV_ZIGZAG_ZERO_FILL_EN: per-bank written-mask, unwritten raster positions drain as zero.
module inv_zigzag_buffer #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [5:0]        in_addr,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_addr,
  output logic              out_last
);

  // Both ports: a word moves on a rising edge where valid && ready; valid never waits on ready,
  // and a presented word with its address/last flag holds stable until accepted.

  if (DEPTH_LOG2 != 6) begin : g_bad_depth
    $error("inv_zigzag_buffer: DEPTH_LOG2 must be 6");
  end

  // ZZ[k] = raster position of zigzag index k.
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_e;
  typedef enum logic {RD_IDLE, RD_READ} rd_state_e;

  logic [DATA_W-1:0] mem_q [0:127];
  bank_state_e       bank_q [2];
  bank_state_e       bank_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              in_ready_q, in_ready_d;
  rd_state_e         rd_state_q;
  logic              rd_bank_q;
  logic [6:0]        rd_cnt_q;
  logic              out_valid_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [5:0]        out_addr_q;

  logic              wr_fire, rd_start, rd_done, rd_chain, rd_issue;
  logic              rd_other;
  logic              rd_sel_bank;
  logic [5:0]        rd_sel_addr;
  logic [5:0]        wr_raster;
  logic [DATA_W-1:0] rd_word;

  assign wr_raster = 6'(ZZ[in_addr]);
  assign rd_other  = rd_bank_q ^ 1'b1;

  always_comb begin
    wr_fire   = in_valid && in_ready_q;
    rd_start  = (rd_state_q == RD_IDLE) && (bank_q[rd_bank_q] == B_FULL);
    rd_done   = out_valid_q && out_ready && out_last_q;
    rd_chain  = rd_done && (bank_q[rd_other] == B_FULL);
    rd_issue  = (rd_state_q == RD_READ) && !rd_cnt_q[6] && (!out_valid_q || out_ready);
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (wr_fire) bank_d[wr_bank_q] = in_last ? B_FULL : B_FILLING;
    if (rd_start) bank_d[rd_bank_q] = B_DRAINING;
    if (rd_done) begin
      bank_d[rd_bank_q] = B_EMPTY;
      if (rd_chain) bank_d[rd_other] = B_DRAINING;
    end
    wr_bank_d  = wr_bank_q ^ (wr_fire && in_last);
    in_ready_d = (bank_d[wr_bank_d] == B_EMPTY) || (bank_d[wr_bank_d] == B_FILLING);
    // On a chained hand-over the first word of the next bank is fetched in the same edge.
    rd_sel_bank = rd_chain ? rd_other : rd_bank_q;
    rd_sel_addr = rd_chain ? 6'd0 : rd_cnt_q[5:0];
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[{wr_bank_q, wr_raster}] <= in_data;
  end

`ifdef INV_ZIGZAG_ZERO_FILL_EN
  logic [63:0] mask_q [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q[0] <= '0;
      mask_q[1] <= '0;
    end else begin
      if (rd_done) mask_q[rd_bank_q] <= '0;
      if (wr_fire) mask_q[wr_bank_q][wr_raster] <= 1'b1;
    end
  end

  assign rd_word = mask_q[rd_sel_bank][rd_sel_addr] ? mem_q[{rd_sel_bank, rd_sel_addr}] : '0;
`else
  assign rd_word = mem_q[{rd_sel_bank, rd_sel_addr}];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]  <= B_EMPTY;
      bank_q[1]  <= B_EMPTY;
      wr_bank_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      wr_bank_q  <= wr_bank_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_start) begin
            rd_state_q <= RD_READ;
            rd_cnt_q   <= '0;
          end
        end
        RD_READ: begin
          if (rd_done) begin
            rd_bank_q <= rd_other;
            if (rd_chain) begin
              out_valid_q <= 1'b1;
              out_data_q  <= rd_word;
              out_addr_q  <= 6'd0;
              out_last_q  <= 1'b0;
              rd_cnt_q    <= 7'd1;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              rd_state_q  <= RD_IDLE;
              rd_cnt_q    <= '0;
            end
          end else if (rd_issue) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rd_word;
            out_addr_q  <= rd_cnt_q[5:0];
            out_last_q  <= (rd_cnt_q[5:0] == 6'd63);
            rd_cnt_q    <= rd_cnt_q + 7'd1;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_inv_zigzag_buffer.sv
// Bench for inv_zigzag_buffer: block-level model (zigzag walk built from diagonals) feeding a raster-order expected queue.
module tb_inv_zigzag_buffer;
  localparam int DATA_W = 8;
  localparam int EW     = DATA_W + 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_data;
  logic [5:0]        in_addr;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic [5:0]        out_addr;

  inv_zigzag_buffer #(.DATA_W(DATA_W), .DEPTH_LOG2(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  // ---------------- clock / reset / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping
  int n_cmp = 0;
  int n_fail = 0;
  logic [EW-1:0]     exp_q[$];
  int                zz[64];
  logic [DATA_W-1:0] mdl_blk[64];
  bit                bp_en = 1'b0;
  int                last_acc_cyc, last_wait;
  int                blk_words = 0, blk_done = 0, stall_seen = 0;
  int                first_cyc[16], last_cyc[16];
  bit                prev_stall = 1'b0;
  logic [EW-1:0]     prev_word, cmp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Zigzag order as a diagonal walk: even diagonals run bottom-left to top-right, odd ones the reverse.
  task automatic build_zz();
    int k, lo, hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
      end
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 64; r++) mdl_blk[r] = '0;
  endtask

  // ---------------- driver
  task automatic send_word(input int idx, input logic [DATA_W-1:0] d, input logic last);
    int waited;
    in_valid = 1'b1;
    in_addr  = 6'(idx);
    in_data  = d;
    in_last  = last;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    last_wait = waited;
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    mdl_blk[zz[idx]] = d;
    if (last) begin
      for (int r = 0; r < 64; r++) exp_q.push_back({(r == 63), 6'(r), mdl_blk[r]});
      clear_model();
      last_acc_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] pat(input int kind, input int k);
    case (kind)
      0:       return DATA_W'(k);
      1:       return DATA_W'(k) ^ 8'hA5;
      default: return DATA_W'(k * 7 + 3);
    endcase
  endfunction

  task automatic send_block(input int kind);
    for (int k = 0; k < 64; k++) send_word(k, pat(kind, k), (k == 63));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < 3000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard / compare process
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      blk_words  = 0;
    end else if (out_valid) begin
      if (prev_stall) check("stall_hold", 64'({out_last, out_addr, out_data}), 64'(prev_word));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_addr), 64'hFFFF);
        end else begin
          cmp_e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(cmp_e[DATA_W-1:0]));
          check("out_addr", 64'(out_addr), 64'(cmp_e[DATA_W+5:DATA_W]));
          check("out_last", 64'(out_last), 64'(cmp_e[DATA_W+6]));
        end
        if (blk_words == 0) first_cyc[blk_done % 16] = cyc;
        blk_words++;
        if (out_last) begin
          check("words_per_block", 64'(blk_words), 64'd64);
          last_cyc[blk_done % 16] = cyc;
          blk_done++;
          blk_words = 0;
        end
      end else begin
        stall_seen++;
      end
      prev_stall = !out_ready;
      prev_word  = {out_last, out_addr, out_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed sequence
  initial begin
    int e, b0, lat;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_addr = '0;
    clear_model();
    build_zz();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);

    // model pins against the standard table (index 61 lands on raster 55)
    check("zz0", 64'(zz[0]), 64'd0);
    check("zz2", 64'(zz[2]), 64'd8);
    check("zz3", 64'(zz[3]), 64'd16);
    check("zz5", 64'(zz[5]), 64'd2);
    check("zz6", 64'(zz[6]), 64'd3);
    check("zz61", 64'(zz[61]), 64'd55);
    check("zz63", 64'(zz[63]), 64'd63);

    // single block, identity data: latency and raster reorder
    send_block(0);
    check("pin_raster8", 64'(exp_q[8][DATA_W-1:0]), 64'd2);
    check("pin_raster2", 64'(exp_q[2][DATA_W-1:0]), 64'd5);
    check("pin_raster63", 64'(exp_q[63][DATA_W-1:0]), 64'd63);
    e = last_acc_cyc;
    lat = -1;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = cyc - e;
    end
    check("first_valid_latency", 64'(lat), 64'd2);
    wait_drain();

    // three blocks back-to-back, one with a duplicated index
    b0 = blk_done;
    send_block(1);
    send_word(5, 8'hEE, 1'b0);
    send_block(2);
    send_word(0, pat(0, 0), 1'b0);
    check("in_ready_low_both_full", 64'(last_wait > 0), 64'd1);
    for (int k = 1; k < 64; k++) send_word(k, pat(0, k), (k == 63));
    wait_drain();
    check("blocks_done_3", 64'(blk_done - b0), 64'd3);
    check("no_bubble_1_to_2", 64'(first_cyc[(b0 + 1) % 16] - last_cyc[b0 % 16]), 64'd1);

    // backpressure
    bp_en = 1'b1;
    b0 = blk_done;
    send_block(0);
    send_block(1);
    wait_drain();
    bp_en = 1'b0;
    check("bp_blocks_done", 64'(blk_done - b0), 64'd2);
    check("bp_stalls_seen", 64'(stall_seen > 0), 64'd1);

    // reset mid-drain and mid-fill, then a fresh block
    send_block(1);
    for (int k = 0; k < 30; k++) send_word(k, pat(2, k), 1'b0);
    rst = 1'b1;
    exp_q.delete();
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    b0 = blk_done;
    send_block(2);
    wait_drain();
    check("rst2_one_block", 64'(blk_done - b0), 64'd1);

`ifdef INV_ZIGZAG_ZERO_FILL_EN
    // sparse block closed early
    send_word(0, 8'h11, 1'b0);
    send_word(1, 8'h22, 1'b0);
    send_word(2, 8'h33, 1'b1);
    check("zf_pin_r0", 64'(exp_q[0][DATA_W-1:0]), 64'h11);
    check("zf_pin_r8", 64'(exp_q[8][DATA_W-1:0]), 64'h33);
    check("zf_pin_r9", 64'(exp_q[9][DATA_W-1:0]), 64'h00);
    wait_drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
